// File: rtl/riscv_core_cache_read_arbiter.sv
// riscv_core_cache_read_arbiter: round-robin sharing of one AXI read channel between I-cache and D-cache refills
module riscv_core_cache_read_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ic_read_req,
  input  logic [ADDR_WIDTH-1:0]     i_ic_read_addr,
  output logic                      o_ic_read_done,
  output logic                      o_ic_read_err,
  output logic [AXI_DATA_WIDTH-1:0] o_ic_block,
  input  logic                      i_dc_read_req,
  input  logic [ADDR_WIDTH-1:0]     i_dc_read_addr,
  output logic                      o_dc_read_done,
  output logic                      o_dc_read_err,
  output logic [AXI_DATA_WIDTH-1:0] o_dc_block,
  output logic                      o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]     o_mem_read_address,
  input  logic                      i_mem_read_done,
  input  logic [AXI_DATA_WIDTH-1:0] i_block_from_axi,
  output logic                      o_bus_timeout
);
  localparam int OFF = $clog2(AXI_DATA_WIDTH / 8);
  localparam int WW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = {{(ADDR_WIDTH - OFF){1'b1}}, {OFF{1'b0}}};
  typedef enum logic [1:0] {IDLE, IC_BUSY, DC_BUSY, RELEASE} state_t;
  state_t state, state_nxt;
  logic last_ic, own_ic, aborted, busy, any_req, grant_ic, timeout;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WW-1:0] wd;
  assign busy     = state == IC_BUSY || state == DC_BUSY;
  assign any_req  = i_ic_read_req || i_dc_read_req;
  // Tie goes to whoever did not own the previous refill
  assign grant_ic = i_ic_read_req && (!i_dc_read_req || !last_ic);
  assign timeout  = busy && !i_mem_read_done && wd == WD_MAX;
  assign o_mem_read_req     = busy;
  assign o_mem_read_address = busy ? (addr & ALIGN) : '0;
  assign o_ic_read_done     = state == RELEASE && own_ic;
  assign o_dc_read_done     = state == RELEASE && !own_ic;
  assign o_ic_read_err      = o_ic_read_done && aborted;
  assign o_dc_read_err      = o_dc_read_done && aborted;
  always_comb begin
    state_nxt = state;
    if (state == IDLE && any_req) state_nxt = grant_ic ? IC_BUSY : DC_BUSY;
    else if (busy && (i_mem_read_done || timeout)) state_nxt = RELEASE;
    else if (state == RELEASE) state_nxt = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_ic       <= 1'b1;
      own_ic        <= 1'b0;
      aborted       <= 1'b0;
      addr          <= '0;
      wd            <= '0;
      o_ic_block    <= '0;
      o_dc_block    <= '0;
      o_bus_timeout <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        own_ic <= grant_ic;
        addr   <= grant_ic ? i_ic_read_addr : i_dc_read_addr;
        wd     <= '0;
      end
      if (busy) wd <= wd + 1'b1;
      if (busy && i_mem_read_done) begin
        aborted <= 1'b0;
        if (own_ic) o_ic_block <= i_block_from_axi;
        else o_dc_block <= i_block_from_axi;
      end
      if (timeout) begin
        aborted       <= 1'b1;
        o_bus_timeout <= 1'b1;
      end
      if (state == RELEASE) last_ic <= own_ic;
    end
  end
endmodule

// File: tb/tb_riscv_core_cache_read_arbiter.sv
// tb_riscv_core_cache_read_arbiter: randomized directed bench against a transaction-level arbiter model
module tb_riscv_core_cache_read_arbiter;
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_ic_read_req = 1'b0, i_dc_read_req = 1'b0, i_mem_read_done = 1'b0;
  logic [31:0]  i_ic_read_addr = '0, i_dc_read_addr = '0;
  logic [255:0] i_block_from_axi = '0;
  logic         o_ic_read_done, o_ic_read_err, o_dc_read_done, o_dc_read_err;
  logic         o_mem_read_req, o_bus_timeout;
  logic [31:0]  o_mem_read_address;
  logic [255:0] o_ic_block, o_dc_block;
  int checks = 0, errors = 0;
  logic [255:0] m_ic_blk = '0, m_dc_blk = '0;
  logic m_last_ic = 1'b1, m_to = 1'b0, win;
  riscv_core_cache_read_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ic_read_req(i_ic_read_req), .i_ic_read_addr(i_ic_read_addr),
    .o_ic_read_done(o_ic_read_done), .o_ic_read_err(o_ic_read_err), .o_ic_block(o_ic_block),
    .i_dc_read_req(i_dc_read_req), .i_dc_read_addr(i_dc_read_addr),
    .o_dc_read_done(o_dc_read_done), .o_dc_read_err(o_dc_read_err), .o_dc_block(o_dc_block),
    .o_mem_read_req(o_mem_read_req), .o_mem_read_address(o_mem_read_address),
    .i_mem_read_done(i_mem_read_done), .i_block_from_axi(i_block_from_axi),
    .o_bus_timeout(o_bus_timeout)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk_blocks(input string tag);
    chk({tag, "_ic_blk"}, o_ic_block, m_ic_blk);
    chk({tag, "_dc_blk"}, o_dc_block, m_dc_blk);
  endtask
  // One refill issued from IDLE; lat = BUSY cycles before the AXI done pulse
  task automatic refill(input logic ic, input logic dc, input logic [31:0] ia, input logic [31:0] da,
                        input int lat, output logic win_ic);
    logic [31:0] wa;
    logic [255:0] data;
    win_ic = ic && (!dc || !m_last_ic);
    wa = (win_ic ? ia : da) & 32'hffff_ffe0;
    data = rand256();
    i_ic_read_req = ic; i_dc_read_req = dc; i_ic_read_addr = ia; i_dc_read_addr = da;
    step();
    chk("grant_req", {31'd0, o_mem_read_req}, 1);
    chk("grant_addr", o_mem_read_address, wa);
    for (int i = 0; i < lat; i++) begin
      i_ic_read_addr = $urandom; i_dc_read_addr = $urandom;
      step();
      chk("busy_req", {31'd0, o_mem_read_req}, 1);
      chk("busy_addr", o_mem_read_address, wa);
      chk("busy_done", {o_ic_read_done, o_dc_read_done}, 0);
    end
    i_mem_read_done = 1'b1; i_block_from_axi = data;
    step();
    i_mem_read_done = 1'b0; i_block_from_axi = rand256();
    if (win_ic) m_ic_blk = data; else m_dc_blk = data;
    chk("rel_req", {31'd0, o_mem_read_req}, 0);
    chk("rel_done", {o_ic_read_done, o_dc_read_done, o_ic_read_err, o_dc_read_err}, {win_ic, !win_ic, 2'b00});
    chk_blocks("rel");
    chk("rel_timeout", {31'd0, o_bus_timeout}, m_to);
    m_last_ic = win_ic;
    if (win_ic) i_ic_read_req = 1'b0; else i_dc_read_req = 1'b0;
    step();
    chk("idle_quiet", {o_mem_read_req, o_ic_read_done, o_dc_read_done}, 0);
  endtask
  initial begin
    logic [3:0] seq;
    int n;
    #12;
    chk("reset_outs", {o_mem_read_req, o_ic_read_done, o_dc_read_done, o_ic_read_err, o_dc_read_err, o_bus_timeout}, 0);
    chk("reset_addr", o_mem_read_address, 0);
    chk_blocks("reset");
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    // DC only, directed address, done on third BUSY cycle
    refill(1'b0, 1'b1, 32'h0, 32'h0000_1234, 2, win);
    chk("dc_first_owner", {31'd0, win}, 0);
    chk("dc_aligned", m_dc_blk === o_dc_block ? 32'h0000_1220 : 32'h0, 32'h0000_1234 & 32'hffff_ffe0);
    // Both held over four refills: alternate starting with IC since DC just owned
    for (int k = 0; k < 4; k++) begin
      refill(1'b1, 1'b1, $urandom, $urandom, $urandom_range(0, 4), win);
      seq[k] = win;
    end
    chk("alternate", {252'd0, seq}, 4'b0101);
    // Random traffic
    for (int k = 0; k < 20; k++) begin
      logic ic, dc;
      ic = 1'($urandom); dc = 1'($urandom);
      if (!ic && !dc) dc = 1'b1;
      refill(ic, dc, $urandom, $urandom, $urandom_range(0, 6), win);
    end
    // Watchdog abort on DC
    i_dc_read_req = 1'b1; i_dc_read_addr = $urandom;
    n = 0;
    do begin
      step();
      if (o_mem_read_req) n++;
    end while (!o_dc_read_done && n < 1100);
    m_to = 1'b1; m_last_ic = 1'b0;
    chk("wd_busy_cycles", n, 1024);
    chk("wd_done", {o_dc_read_done, o_dc_read_err, o_ic_read_done, o_ic_read_err}, 4'b1100);
    chk("wd_timeout", {31'd0, o_bus_timeout}, 1);
    chk_blocks("wd");
    i_dc_read_req = 1'b0;
    i_mem_read_done = 1'b1; i_block_from_axi = rand256();
    step();
    step();
    i_mem_read_done = 1'b0;
    chk("late_done_ignored", {o_mem_read_req, o_ic_read_done, o_dc_read_done}, 0);
    chk_blocks("late");
    refill(1'b1, 1'b0, $urandom, 32'h0, 1, win);
    chk("post_wd_ic", {31'd0, win}, 1);
    // Async reset mid DC refill
    i_dc_read_req = 1'b1; i_dc_read_addr = $urandom;
    step();
    step();
    chk("pre_rst_busy", {31'd0, o_mem_read_req}, 1);
    #2 i_rst_n = 1'b0;
    #1;
    m_ic_blk = '0; m_dc_blk = '0; m_to = 1'b0; m_last_ic = 1'b1;
    chk("rst_outs", {o_mem_read_req, o_ic_read_done, o_dc_read_done, o_ic_read_err, o_dc_read_err, o_bus_timeout}, 0);
    chk("rst_addr", o_mem_read_address, 0);
    chk_blocks("rst");
    i_dc_read_req = 1'b0;
    step();
    i_rst_n = 1'b1;
    step();
    chk("post_rst_quiet", {o_ic_read_done, o_dc_read_done}, 0);
    refill(1'b1, 1'b1, $urandom, $urandom, 3, win);
    chk("post_rst_tie_dc", {31'd0, win}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
